// File: rtl/hpc3_rand_gen_if.sv
// Randomness bundle between the HPC3 generator and its consuming multiplier.
// The master side is the generator; the slave side is the multiplier.
interface hpc3_rand_gen_if #(
  parameter int RW = 2
);
  logic [63:0]   in_seed;
  logic          in_seed_valid;
  logic          out_seed_ready;
  logic [RW-1:0] out_r;
  logic [RW-1:0] out_p;
  logic          out_valid;
  logic          in_ready;
  logic          out_reseed_req;

  modport master (
    input  in_seed, in_seed_valid, in_ready,
    output out_seed_ready, out_r, out_p, out_valid, out_reseed_req
  );

  modport slave (
    output in_seed, in_seed_valid, in_ready,
    input  out_seed_ready, out_r, out_p, out_valid, out_reseed_req
  );
endinterface

// File: rtl/hpc3_rand_gen.sv
// Seeded 64-bit LFSR feeding fresh r/p words to an HPC3 multiplier.
// Warms up after every seed and asks for a new seed after a word budget.
module hpc3_rand_gen #(
    parameter int NUM_SHARES    = 2,
    parameter int BIT_WIDTH     = 2,
    parameter int WARMUP_CYCLES = 16,
    parameter int RESEED_LIMIT  = 1024
) (
    input logic            in_clock,
    input logic            in_reset,
    hpc3_rand_gen_if.master bus
);

    function automatic int num_quad(int n);
        return n * (n - 1) / 2;
    endfunction

    localparam int NQ = num_quad(NUM_SHARES);
    localparam int RW = NQ * BIT_WIDTH;
    localparam int OW = 2 * RW;

    localparam logic [7:0]  WARM_LAST = 8'(WARMUP_CYCLES - 1);
    localparam logic [20:0] WORD_LAST = 21'(RESEED_LIMIT - 1);

    generate
        if (OW > 64 || OW < 2) begin : g_bad_width
            $error("hpc3_rand_gen: OW must be in 2..64");
        end
        if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 255) begin : g_bad_warm
            $error("hpc3_rand_gen: WARMUP_CYCLES out of range");
        end
        if (RESEED_LIMIT < 1 || RESEED_LIMIT > (1 << 20)) begin : g_bad_lim
            $error("hpc3_rand_gen: RESEED_LIMIT out of range");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

    function automatic logic [63:0] advance(logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < OW; i++) begin
            t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        end
        return t;
    endfunction

    state_t      state_q, state_d;
    logic [63:0] lfsr_q;
    logic [63:0] lfsr_nx;
    logic [7:0]  warm_q;
    logic [20:0] words_q;
    logic        reseed_q;
    logic        seed_ld;
    logic        hs;
    logic        warm_done;
    logic        last_wd;
    logic        run;

    assign lfsr_nx   = advance(lfsr_q);
    assign run       = (state_q == RUN);
    assign seed_ld   = bus.in_seed_valid && (state_q != WARMUP);
    assign hs        = run && bus.in_ready;
    assign warm_done = (warm_q == WARM_LAST);
    assign last_wd   = (words_q == WORD_LAST);

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_seed_valid) state_d = WARMUP;
            WARMUP:  if (warm_done) state_d = RUN;
            RUN: begin
                if (bus.in_seed_valid)   state_d = WARMUP;
                else if (hs && last_wd)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A reseed overrides a simultaneous handshake: reload, no advance.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            lfsr_q   <= 64'h1;
            warm_q   <= '0;
            words_q  <= '0;
            reseed_q <= 1'b0;
        end else if (seed_ld) begin
            lfsr_q   <= (bus.in_seed == 64'h0) ? 64'h1 : bus.in_seed;
            warm_q   <= '0;
            words_q  <= '0;
            reseed_q <= 1'b0;
        end else if (state_q == WARMUP) begin
            lfsr_q <= lfsr_nx;
            warm_q <= warm_q + 8'd1;
        end else if (hs) begin
            lfsr_q  <= lfsr_nx;
            words_q <= words_q + 21'd1;
            if (last_wd) reseed_q <= 1'b1;
        end
    end

    // Words are masked outside RUN so warmup state never leaks out.
    always_comb begin
        bus.out_valid      = run;
        bus.out_seed_ready = (state_q != WARMUP);
        bus.out_reseed_req = reseed_q;
        bus.out_r          = '0;
        bus.out_p          = '0;
        if (run) begin
            bus.out_r = lfsr_q[RW-1:0];
            bus.out_p = lfsr_q[OW-1:RW];
        end
    end

endmodule

// File: tb/tb_hpc3_rand_gen.sv
// Scoreboard bench for hpc3_rand_gen with a 4-word reseed budget.
// Directed seeds; expected words come from an independent LFSR model.
module tb_hpc3_rand_gen;

    localparam int RW   = 2;
    localparam int OW   = 4;
    localparam int WARM = 16;
    localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
    localparam logic [63:0] S1   = 64'h0123456789ABCDEF;
    localparam logic [63:0] S2   = 64'hFEDCBA9876543210;
    localparam logic [63:0] S3   = 64'hDEADBEEFCAFEF00D;
    localparam logic [63:0] S4   = 64'h0F1E2D3C4B5A6978;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   hs_cnt;
    logic [OW-1:0] exp_q[$];

    hpc3_rand_gen_if #(.RW(RW)) bus ();

    hpc3_rand_gen #(
        .NUM_SHARES(2),
        .BIT_WIDTH(2),
        .WARMUP_CYCLES(WARM),
        .RESEED_LIMIT(4)
    ) dut (
        .in_clock(clk),
        .in_reset(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] m_adv(logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < OW; i++) t = {t[62:0], ^(t & TAPS)};
        return t;
    endfunction

    function automatic logic [63:0] m_warm(logic [63:0] seed);
        logic [63:0] t;
        t = (seed == 64'h0) ? 64'h1 : seed;
        for (int i = 0; i < WARM; i++) t = m_adv(t);
        return t;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'h0);
        chk({tag, "_sready"}, 64'(bus.out_seed_ready), 64'h1);
        chk({tag, "_rreq"}, 64'(bus.out_reseed_req), 64'h0);
        chk({tag, "_r"}, 64'(bus.out_r), 64'h0);
        chk({tag, "_p"}, 64'(bus.out_p), 64'h0);
    endtask

    task automatic load_seed(logic [63:0] s, logic rdy);
        @(posedge clk);
        #1;
        bus.in_seed       = s;
        bus.in_seed_valid = 1'b1;
        bus.in_ready      = rdy;
        @(posedge clk);
        #1;
        bus.in_seed_valid = 1'b0;
        bus.in_ready      = 1'b0;
    endtask

    task automatic warm_chk(string tag, logic [63:0] seed);
        logic [63:0] m;
        int          early;
        m     = m_warm(seed);
        early = 0;
        for (int i = 0; i < WARM; i++) begin
            @(negedge clk);
            if (bus.out_valid) early++;
        end
        chk({tag, "_warm_valid_cnt"}, 64'(early), 64'h0);
        @(negedge clk);
        chk({tag, "_valid_rise"}, 64'(bus.out_valid), 64'h1);
        chk({tag, "_word"}, 64'({bus.out_p, bus.out_r}), 64'(m[OW-1:0]));
    endtask

    // Monitor: every accepted word must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.in_ready && !bus.in_seed_valid) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got %h expected none",
                         {bus.out_p, bus.out_r});
            end else begin
                chk("sb_word", 64'({bus.out_p, bus.out_r}),
                    64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [63:0] m;
        logic [OW-1:0] w0;
        errors = 0;
        checks = 0;
        hs_cnt = 0;
        rst_n  = 1'b0;
        bus.in_seed       = '0;
        bus.in_seed_valid = 1'b0;
        bus.in_ready      = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        rst_n = 1'b1;

        // seed S1, 16-cycle warmup
        load_seed(S1, 1'b0);
        warm_chk("s1", S1);

        // hold for 5 cycles: word must stay put
        m  = m_warm(S1);
        w0 = m[OW-1:0];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("hold_word", 64'({bus.out_p, bus.out_r}), 64'(w0));
        end

        // three handshakes, then the fourth hits the budget
        hs_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(m[OW-1:0]);
            m = m_adv(m);
        end
        @(posedge clk);
        #1;
        bus.in_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.in_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.in_ready = 1'b0;
        @(negedge clk);
        chk("hs_cnt", 64'(hs_cnt), 64'd4);
        chk("lim_valid", 64'(bus.out_valid), 64'h0);
        chk("lim_rreq", 64'(bus.out_reseed_req), 64'h1);
        chk("lim_sready", 64'(bus.out_seed_ready), 64'h1);

        // zero seed behaves as seed 1; hand value after warmup is 4'hB
        load_seed(64'h0, 1'b0);
        @(negedge clk);
        chk("s0_rreq_clr", 64'(bus.out_reseed_req), 64'h0);
        chk("s0_sready_warm", 64'(bus.out_seed_ready), 64'h0);
        for (int i = 0; i < WARM - 1; i++) @(negedge clk);
        @(negedge clk);
        chk("s0_valid", 64'(bus.out_valid), 64'h1);
        chk("s0_hand_word", 64'({bus.out_p, bus.out_r}), 64'hB);
        chk("s0_vs_s1", 64'({bus.out_p, bus.out_r}),
            64'(m_warm(64'h1) & 64'hF));

        // seed colliding with a handshake: reseed wins, no word taken
        hs_cnt = 0;
        load_seed(S2, 1'b1);
        warm_chk("s2", S2);
        chk("collide_no_hs", 64'(hs_cnt), 64'd0);

        // reset in the middle of warmup
        load_seed(S3, 1'b0);
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 64'(bus.out_valid), 64'h0);
        load_seed(S4, 1'b0);
        warm_chk("s4", S4);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
